// File: rtl/conv2d_oc_scheduler.sv
// conv2d_oc_scheduler: sequences the per-window output-channel loop (weight reads, PE starts, result slots, vector handshake).
// Optional watchdog enabled by defining CONV2D_SCHED_TIMEOUT_EN.
module conv2d_oc_scheduler #(
    parameter int NUM_OUT_CHANNELS = 16,
    parameter int ADDR_W           = 8,
    parameter int BRAM_LATENCY     = 1,
    parameter int TIMEOUT          = 64,
    parameter int CH_W             = $clog2(NUM_OUT_CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              win_valid,
    output logic              win_ready,
    output logic              wt_rd_en,
    output logic [ADDR_W-1:0] wt_rd_addr,
    output logic              pe_start,
    output logic [CH_W-1:0]   pe_ch,
    input  logic              pe_done,
    output logic              res_we,
    output logic [CH_W-1:0]   res_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, EMIT} state_t;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_OUT_CHANNELS - 1);

    if (NUM_OUT_CHANNELS < 2 || BRAM_LATENCY < 1 || TIMEOUT < 1) begin : g_cfg_check
        $error("conv2d_oc_scheduler: illegal parameter set");
    end

    state_t                             state_q;
    logic [ADDR_W-1:0]                  base_q;
    logic [CH_W-1:0]                    issue_ch_q, done_cnt_q;
    logic [CH_W:0]                      outst_q, outst_d;
    logic [BRAM_LATENCY-1:0]            pv_q;
    logic [BRAM_LATENCY-1:0][CH_W-1:0]  pc_q;
    logic                               err_overrun_q, done_ok, timeout_hit;

    assign win_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign out_valid   = state_q == EMIT;
    assign wt_rd_en    = state_q == ISSUE;
    assign wt_rd_addr  = base_q + ADDR_W'(issue_ch_q);
    assign pe_start    = pv_q[BRAM_LATENCY-1];
    assign pe_ch       = pc_q[BRAM_LATENCY-1];
    assign res_we      = done_ok;
    assign res_idx     = done_cnt_q;
    assign err_overrun = err_overrun_q;

    // A result is only accepted while a started channel is still outstanding
    always_comb begin
        done_ok = pe_done && outst_q != '0 && (state_q == ISSUE || state_q == COLLECT);
        outst_d = outst_q + (CH_W+1)'(pe_start) - (CH_W+1)'(done_ok);
    end

`ifdef CONV2D_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_timeout_q;
    assign timeout_hit = state_q == COLLECT && !pe_done && wd_q == WD_W'(TIMEOUT - 1);
    assign err_timeout = err_timeout_q;
    // Watchdog restarts on any result and outside COLLECT, so it only measures a stalled collect phase
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_q <= (pe_done || state_q != COLLECT) ? '0 : wd_q + 1'b1;
            if (timeout_hit) err_timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Main FSM, start pipe aligned to BRAM latency, and result/outstanding counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            issue_ch_q    <= '0;
            done_cnt_q    <= '0;
            outst_q       <= '0;
            pv_q          <= '0;
            pc_q          <= '0;
            err_overrun_q <= 1'b0;
        end else begin
            outst_q <= outst_d;
            pv_q[0] <= wt_rd_en;
            pc_q[0] <= issue_ch_q;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
            if (pe_done && !done_ok) err_overrun_q <= 1'b1;
            if (done_ok) done_cnt_q <= done_cnt_q + 1'b1;
            case (state_q)
                IDLE: if (win_valid) begin
                    base_q     <= cfg_base;
                    issue_ch_q <= '0;
                    done_cnt_q <= '0;
                    state_q    <= ISSUE;
                end
                ISSUE: begin
                    issue_ch_q <= issue_ch_q + 1'b1;
                    if (issue_ch_q == LAST_CH) state_q <= COLLECT;
                end
                COLLECT: if (done_ok && done_cnt_q == LAST_CH) begin
                    state_q <= EMIT;
                end else if (timeout_hit) begin
                    state_q <= IDLE;
                    pv_q    <= '0;
                    outst_q <= '0;
                end
                default: if (out_ready) state_q <= IDLE;
            endcase
        end
    end
endmodule
